// File: rtl/stim_sequencer.sv
// Vector-table stimulus sequencer: issues stored stimuli over valid/ready,
// waits for each result and strobes (actual, expected) pairs to a checker.
module stim_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_en,
    input  logic [AW-1:0]    i_load_addr,
    input  logic [WIDTH-1:0] i_load_stim,
    input  logic [WIDTH-1:0] i_load_exp,
    input  logic             i_start,
    input  logic [AW:0]      i_num_tests,
    output logic [WIDTH-1:0] o_stim,
    output logic             o_stim_valid,
    input  logic             i_stim_ready,
    input  logic [WIDTH-1:0] i_res,
    input  logic             i_res_valid,
    output logic             o_chk_valid,
    output logic [WIDTH-1:0] o_chk_actual,
    output logic [WIDTH-1:0] o_chk_expctd,
    output logic [AW-1:0]    o_chk_idx,
    output logic [AW:0]      o_pass_cnt,
    output logic [AW:0]      o_fail_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LP_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] LP_IONE  = AW'(1);
    localparam logic [7:0]    LP_TO    = 8'(TIMEOUT);

    state_t           r_state;
    logic [WIDTH-1:0] r_stim_tbl [DEPTH];
    logic [WIDTH-1:0] r_exp_tbl  [DEPTH];
    logic [AW-1:0]    r_idx;
    logic [AW:0]      r_n;
    logic [7:0]       r_timer;
    logic             r_force_fail;
    logic [WIDTH-1:0] r_stim;
    logic             r_stim_valid;
    logic             r_chk_valid;
    logic [WIDTH-1:0] r_chk_actual;
    logic [WIDTH-1:0] r_chk_expctd;
    logic [AW-1:0]    r_chk_idx;
    logic [AW:0]      r_pass_cnt;
    logic [AW:0]      r_fail_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;

    logic             w_load;
    logic [AW:0]      w_n;
    logic [WIDTH-1:0] w_stim0;
    logic [AW-1:0]    w_idx_nxt;
    logic             w_last;
    logic             w_pass;

    assign w_load    = i_load_en &&
                       (r_state == S_IDLE || r_state == S_DONE);
    assign w_n       = (i_num_tests > LP_DEPTH) ? LP_DEPTH : i_num_tests;
    // A same-cycle write to entry 0 must reach the first issued stimulus
    assign w_stim0   = (w_load && i_load_addr == '0) ? i_load_stim
                                                     : r_stim_tbl[0];
    assign w_idx_nxt = r_idx + LP_IONE;
    assign w_last    = ({1'b0, r_idx} == (r_n - LP_ONE));
    assign w_pass    = (r_chk_actual == r_chk_expctd) && !r_force_fail;

    always_ff @(posedge i_clk) begin
        if (w_load) begin
            r_stim_tbl[i_load_addr] <= i_load_stim;
            r_exp_tbl[i_load_addr]  <= i_load_exp;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_n          <= '0;
            r_timer      <= '0;
            r_force_fail <= 1'b0;
            r_stim       <= '0;
            r_stim_valid <= 1'b0;
            r_chk_valid  <= 1'b0;
            r_chk_actual <= '0;
            r_chk_expctd <= '0;
            r_chk_idx    <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_n        <= w_n;
                        r_idx      <= '0;
                        r_pass_cnt <= '0;
                        r_fail_cnt <= '0;
                        r_timeout  <= 1'b0;
                        if (w_n == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= S_ISSUE;
                            r_done       <= 1'b0;
                            r_busy       <= 1'b1;
                            r_stim       <= w_stim0;
                            r_stim_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_stim_ready) begin
                        r_state      <= S_WAIT;
                        r_stim_valid <= 1'b0;
                        r_timer      <= '0;
                    end
                end
                S_WAIT: begin
                    // A result in the deadline cycle still beats the timeout
                    if (i_res_valid || r_timer == LP_TO) begin
                        r_state      <= S_CHECK;
                        r_chk_valid  <= 1'b1;
                        r_chk_actual <= i_res_valid ? i_res : '0;
                        r_force_fail <= !i_res_valid;
                        r_chk_expctd <= r_exp_tbl[r_idx];
                        r_chk_idx    <= r_idx;
                        if (!i_res_valid) begin
                            r_timeout <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_CHECK: begin
                    r_chk_valid <= 1'b0;
                    if (w_pass) begin
                        r_pass_cnt <= r_pass_cnt + LP_ONE;
                    end else begin
                        r_fail_cnt <= r_fail_cnt + LP_ONE;
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_ISSUE;
                        r_idx        <= w_idx_nxt;
                        r_stim       <= r_stim_tbl[w_idx_nxt];
                        r_stim_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_stim       = r_stim;
    assign o_stim_valid = r_stim_valid;
    assign o_chk_valid  = r_chk_valid;
    assign o_chk_actual = r_chk_actual;
    assign o_chk_expctd = r_chk_expctd;
    assign o_chk_idx    = r_chk_idx;
    assign o_pass_cnt   = r_pass_cnt;
    assign o_fail_cnt   = r_fail_cnt;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_timeout    = r_timeout;

endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
Synthesizable stimulus side of the FRANK6000 test flow. It holds a small table of (stimulus, expected) pairs and issues each stimulus to a unit under test over a valid/ready handshake. It waits for the unit's result and presents each (actual, expected) pair to the checker with a one-cycle strobe. It also keeps pass/fail/timeout accounting for benches and on-board self-test.

Parameters:
WIDTH, 8, data width of stimulus, result and expected values
DEPTH, 16, number of vector table entries
AW, 4, table address width; DEPTH = 2**AW
TIMEOUT, 255, maximum WAIT cycles before a vector is declared timed out (1..255)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_load_en  in  1  write one table entry this cycle
i_load_addr  in  AW  table entry index
i_load_stim  in  WIDTH  stimulus value to store
i_load_exp  in  WIDTH  expected result to store
i_start  in  1  begin a run (single-cycle pulse)
i_num_tests  in  AW+1  number of vectors to run, sampled at start
o_stim  out  WIDTH  stimulus to the unit under test
o_stim_valid  out  1  stimulus valid
i_stim_ready  in  1  unit accepts stimulus
i_res  in  WIDTH  result from the unit
i_res_valid  in  1  result valid (single-cycle)
o_chk_valid  out  1  check pair valid, one cycle per vector
o_chk_actual  out  WIDTH  captured result
o_chk_expctd  out  WIDTH  expected result
o_chk_idx  out  AW  index of the vector being checked
o_pass_cnt  out  AW+1  vectors passed this run
o_fail_cnt  out  AW+1  vectors failed this run, timeouts included
o_busy  out  1  run in progress
o_done  out  1  run finished; held until next start
o_timeout  out  1  sticky; at least one vector timed out this run

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; idx, timer and counters 0. The table is not reset.
- State machine:
  - IDLE: on i_start, latch n = min(i_num_tests, DEPTH). Clear the pass/fail counters and o_timeout; set idx=0. If n=0, go to DONE; otherwise go to ISSUE.
  - ISSUE: o_stim_valid=1 and o_stim=stim[idx], stable until accepted. When i_stim_valid and i_stim_ready are both 1 at a clock edge, the stimulus is accepted; go to WAIT with timer=0. ISSUE may last indefinitely; there is no timeout here.
  - WAIT: on i_res_valid, capture i_res into actual; go to CHECK. Otherwise increment the timer. When the timer equals TIMEOUT without a result: set actual=0, set a force-fail flag and o_timeout=1; go to CHECK.
  - CHECK (exactly 1 cycle): o_chk_valid=1; o_chk_actual=actual, o_chk_expctd=exp[idx], o_chk_idx=idx. Pass means actual==expected and no force-fail; increment o_pass_cnt on pass, else o_fail_cnt. If idx==n-1 go to DONE, else idx+1 and go to ISSUE.
  - DONE: o_done=1, o_busy=0. Counters hold their values. i_start starts a new run exactly as from IDLE.
- o_busy=1 in ISSUE, WAIT and CHECK. o_chk_* data outputs hold their last values outside CHECK.
- Latency: minimum 3 cycles per vector (ISSUE accepted first cycle, result the cycle after, CHECK).
- Table writes are accepted in IDLE and DONE only; i_load_en is ignored while o_busy=1. A write and i_start in the same IDLE cycle: both take effect, and the write is visible to the run.
- Ignored inputs:
  - i_start while busy.
  - i_res_valid outside WAIT, including in the same cycle as the ISSUE handshake.
- An i_res_valid arriving in the same cycle the timer reaches TIMEOUT wins: the result is captured and the vector is not a timeout.
- Counter width AW+1 holds DEPTH without wrap.
- i_rst asserted mid-run aborts immediately to IDLE with outputs 0. The unit under test is not notified.

Test Plan:
- Load 4 vectors stim 01,02,03,04 / exp 02,04,06,08. Model the unit as ready=1, result=2*stim one cycle after accept. Start with num=4 -> 4 o_chk_valid pulses, idx 0..3, pass=4, fail=0, o_done=1, total 12 cycles from start to done.
- Same setup but the unit returns 05 for idx 2 -> pass=3, fail=1; the third check shows actual=05, expected=06, idx=2.
- Unit never responds for idx 1, TIMEOUT=10 -> check for idx 1 shows actual=00; fail=1, o_timeout=1; the run continues to done.
- Hold i_stim_ready=0 for 5 cycles -> o_stim_valid stays 1 and o_stim stays 01, no timeout; the run completes normally after ready rises.
- num=0 -> o_done next cycle, no o_chk_valid. num=31 with DEPTH=16 -> exactly 16 checks.
- Assert i_rst during WAIT of idx 2 -> all outputs 0 asynchronously, state IDLE. A following start reruns from idx 0 with counters cleared.
